// File: rtl/cg_ctrl_pkg.sv
// Shared types and sizing helpers for the clock-gate sequencer.
// The optional auto-idle feature is selected by CG_CTRL_AUTO_IDLE_EN.
package cg_ctrl_pkg;

  typedef enum logic [2:0] {
    CG_OFF   = 3'd0,
    CG_WAKE  = 3'd1,
    CG_ON    = 3'd2,
    CG_DRAIN = 3'd3,
    CG_SLEEP = 3'd4
  } cg_state_t;

  function automatic int cg_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cg_cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cg_ctrl_ch.sv
// Single clock-gate channel: OFF/WAKE/ON/DRAIN sequencing with settle and drain
// delays; SLEEP and the idle counter exist only with CG_CTRL_AUTO_IDLE_EN.
module cg_ctrl_ch
  import cg_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int DRAIN_CYCLES  = 8,
  parameter int IDLE_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic idle_i,
  output logic en_o,
  output logic ack_o,
  output logic busy_o
);

  localparam int CNT_W = cg_cnt_width(cg_max(SETTLE_CYCLES, DRAIN_CYCLES));
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_CYCLES - 1);

  cg_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;

`ifdef CG_CTRL_AUTO_IDLE_EN
  localparam int IDLE_W = cg_cnt_width(IDLE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_ZERO = IDLE_W'(0);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              rewake_q, rewake_d;
`else
  localparam int unused_idle_cycles_p = IDLE_CYCLES;
  logic unused_idle_s;
  assign unused_idle_s = idle_i;
`endif

  // Next-state, counter and registered-output decode for one channel.
  always_comb begin
    state_d = state_q;
    if (cnt_q == CNT_ZERO) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q - CNT_ONE;
    end
`ifdef CG_CTRL_AUTO_IDLE_EN
    idle_cnt_d = IDLE_ZERO;
`endif

    case (state_q)
      CG_OFF: begin
        if (req_i) begin
          state_d = CG_WAKE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          state_d = CG_OFF;
        end
      end
      CG_WAKE: begin
        if (!req_i) begin
          state_d = CG_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = CG_ON;
        end else begin
          state_d = CG_WAKE;
        end
      end
      CG_ON: begin
        if (!req_i) begin
          state_d = CG_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end else begin
          state_d = CG_ON;
`ifdef CG_CTRL_AUTO_IDLE_EN
          if (idle_i) begin
            if (idle_cnt_q == IDLE_LAST) begin
              state_d = CG_SLEEP;
            end else begin
              idle_cnt_d = idle_cnt_q + IDLE_ONE;
            end
          end else begin
            idle_cnt_d = IDLE_ZERO;
          end
`endif
        end
      end
      CG_DRAIN: begin
        // The clock never stopped, so a re-request skips the settle delay.
        if (req_i) begin
          state_d = CG_ON;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = CG_OFF;
        end else begin
          state_d = CG_DRAIN;
        end
      end
      CG_SLEEP: begin
`ifdef CG_CTRL_AUTO_IDLE_EN
        if (!req_i) begin
          state_d = CG_OFF;
        end else if (!idle_i) begin
          state_d = CG_WAKE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          state_d = CG_SLEEP;
        end
`else
        state_d = CG_OFF;
`endif
      end
      default: begin
        state_d = CG_OFF;
        cnt_d   = CNT_ZERO;
      end
    endcase

    en_d   = (state_d == CG_WAKE) || (state_d == CG_ON) || (state_d == CG_DRAIN);
    busy_d = (state_d == CG_WAKE) || (state_d == CG_DRAIN);
`ifdef CG_CTRL_AUTO_IDLE_EN
    // A re-wake out of SLEEP keeps the grant asserted while settling.
    rewake_d = (state_d == CG_WAKE) && (rewake_q || (state_q == CG_SLEEP));
    ack_d    = (state_d == CG_ON) || (state_d == CG_SLEEP) || rewake_d;
`else
    ack_d    = (state_d == CG_ON);
`endif
  end

  // Channel state, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CG_OFF;
      cnt_q      <= CNT_ZERO;
      en_q       <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef CG_CTRL_AUTO_IDLE_EN
      idle_cnt_q <= IDLE_ZERO;
      rewake_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
`ifdef CG_CTRL_AUTO_IDLE_EN
      idle_cnt_q <= idle_cnt_d;
      rewake_q   <= rewake_d;
`endif
    end
  end

  assign en_o   = en_q;
  assign ack_o  = ack_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/cg_ctrl.sv
// N_CH-channel clock-gate enable sequencer with test override of the enables.
// Optional auto-idle gating is enabled by defining CG_CTRL_AUTO_IDLE_EN.
module cg_ctrl
  import cg_ctrl_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int DRAIN_CYCLES  = 8,
  parameter int IDLE_CYCLES   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req_i,
  output logic [N_CH-1:0] ack_o,
  output logic [N_CH-1:0] en_o,
  input  logic            force_en_i,
  input  logic [N_CH-1:0] idle_i,
  output logic [N_CH-1:0] busy_o
);

  logic [N_CH-1:0] fsm_en_s;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    cg_ctrl_ch #(
      .SETTLE_CYCLES(SETTLE_CYCLES),
      .DRAIN_CYCLES (DRAIN_CYCLES),
      .IDLE_CYCLES  (IDLE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .req_i (req_i[g]),
      .idle_i(idle_i[g]),
      .en_o  (fsm_en_s[g]),
      .ack_o (ack_o[g]),
      .busy_o(busy_o[g])
    );
  end

  // Quasi-static test override ORed after the enable registers.
  assign en_o = fsm_en_s | {N_CH{force_en_i}};

endmodule

// File: tb/tb_cg_ctrl.sv
// Directed, table-driven bench for cg_ctrl (SETTLE=4, DRAIN=8, IDLE=16).
module tb_cg_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_i;
  logic [3:0] ack_o;
  logic [3:0] en_o;
  logic       force_en_i;
  logic [3:0] idle_i;
  logic [3:0] busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  cg_ctrl #(
    .N_CH(4), .SETTLE_CYCLES(4), .DRAIN_CYCLES(8), .IDLE_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .ack_o     (ack_o),
    .en_o      (en_o),
    .force_en_i(force_en_i),
    .idle_i    (idle_i),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       frc;
    int         adv;
    logic [3:0] en;
    logic [3:0] ack;
    logic [3:0] busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] req, input logic frc, input int adv,
                     input logic [3:0] en, input logic [3:0] ack, input logic [3:0] busy);
    vec_t v;
    v.req = req; v.frc = frc; v.adv = adv; v.en = en; v.ack = ack; v.busy = busy;
    vecs.push_back(v);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] en,
                           input logic [3:0] ack, input logic [3:0] busy);
    check({tag, " en"}, en_o, en);
    check({tag, " ack"}, ack_o, ack);
    check({tag, " busy"}, busy_o, busy);
  endtask

  initial begin
    rst = 1'b1; req_i = 4'h0; force_en_i = 1'b0; idle_i = 4'h0;
    step(3);
    check_all("reset", 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    step(2);
    check_all("post_reset", 4'h0, 4'h0, 4'h0);

    // ch0 wake and release
    add(4'h1, 1'b0, 1, 4'h1, 4'h0, 4'h1);
    add(4'h1, 1'b0, 3, 4'h1, 4'h0, 4'h1);
    add(4'h1, 1'b0, 1, 4'h1, 4'h1, 4'h0);
    add(4'h0, 1'b0, 1, 4'h1, 4'h0, 4'h1);
    add(4'h0, 1'b0, 7, 4'h1, 4'h0, 4'h1);
    add(4'h0, 1'b0, 1, 4'h0, 4'h0, 4'h0);
    // ch2 abort in WAKE: en for 2 + DRAIN cycles
    add(4'h4, 1'b0, 2, 4'h4, 4'h0, 4'h4);
    add(4'h0, 1'b0, 8, 4'h4, 4'h0, 4'h4);
    add(4'h0, 1'b0, 1, 4'h0, 4'h0, 4'h0);
    // force override, idle and during ON
    add(4'h0, 1'b1, 0, 4'hF, 4'h0, 4'h0);
    add(4'h0, 1'b0, 0, 4'h0, 4'h0, 4'h0);
    add(4'h1, 1'b1, 5, 4'hF, 4'h1, 4'h0);
    add(4'h1, 1'b0, 0, 4'h1, 4'h1, 4'h0);
    add(4'h0, 1'b0, 9, 4'h0, 4'h0, 4'h0);
    // two channels together
    add(4'hA, 1'b0, 5, 4'hA, 4'hA, 4'h0);
    add(4'h8, 1'b0, 1, 4'hA, 4'h8, 4'h2);
    add(4'h0, 1'b0, 9, 4'h0, 4'h0, 4'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      req_i      = vecs[i].req;
      force_en_i = vecs[i].frc;
      if (vecs[i].adv > 0) step(vecs[i].adv);
      else #1;
      check_all($sformatf("vec%0d", i), vecs[i].en, vecs[i].ack, vecs[i].busy);
    end

    // ch1 re-request during DRAIN: ack returns next cycle, en never drops
    req_i = 4'h2;
    step(5);
    check_all("rereq_on", 4'h2, 4'h2, 4'h0);
    req_i = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_all($sformatf("rereq_drain%0d", i), 4'h2, 4'h0, 4'h2);
    end
    req_i = 4'h2;
    step(1);
    check_all("rereq_back", 4'h2, 4'h2, 4'h0);
    req_i = 4'h0;
    step(9);
    check_all("rereq_off", 4'h0, 4'h0, 4'h0);

    // reset mid-WAKE
    req_i = 4'h1;
    step(2);
    check_all("rst_wake_pre", 4'h1, 4'h0, 4'h1);
    rst = 1'b1;
    step(1);
    check_all("rst_wake", 4'h0, 4'h0, 4'h0);
    rst = 1'b0; req_i = 4'h0;
    step(1);
    check_all("rst_wake_post", 4'h0, 4'h0, 4'h0);

    // ch3 idle behaviour
    req_i = 4'h8;
    step(5);
    check_all("idle_on", 4'h8, 4'h8, 4'h0);
    idle_i = 4'h8;
`ifdef CG_CTRL_AUTO_IDLE_EN
    step(15);
    check_all("idle_15", 4'h8, 4'h8, 4'h0);
    step(1);
    check_all("sleep", 4'h0, 4'h8, 4'h0);
    idle_i = 4'h0;
    step(1);
    check_all("rewake", 4'h8, 4'h8, 4'h8);
    step(3);
    check_all("rewake_settle", 4'h8, 4'h8, 4'h8);
    step(1);
    check_all("rewake_on", 4'h8, 4'h8, 4'h0);
    idle_i = 4'h8;
    step(16);
    check_all("sleep2", 4'h0, 4'h8, 4'h0);
    req_i = 4'h0;
    step(1);
    check_all("sleep_off", 4'h0, 4'h0, 4'h0);
    idle_i = 4'h0;
`else
    step(20);
    check_all("idle_ignored", 4'h8, 4'h8, 4'h0);
    idle_i = 4'h0; req_i = 4'h0;
    step(9);
    check_all("idle_off", 4'h0, 4'h0, 4'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cg_ctrl.md
Name: cg_ctrl

Overview:
- Sequences N_CH clock-gate enables for subsystem clock domains. Each en_o bit drives the en input of one tech_cg instance.
- Each channel has a per-channel req/ack handshake. The controller adds a settle delay before acknowledging wake-up and a drain delay before gating.
- Sits in the SoC control domain on the ungated clock; fed by SoC control registers or subsystem wrappers.

Parameters:
- N_CH, 4, number of gated clock channels.
- SETTLE_CYCLES, 4, cycles en_o is high before ack_o asserts (range 1..255).
- DRAIN_CYCLES, 8, cycles en_o stays high after req_i drops (range 1..255).
- IDLE_CYCLES, 16, consecutive idle_i cycles before auto-gating (only used with CG_CTRL_AUTO_IDLE_EN; range 1..65535).

Ports:
- clk  in  1  ungated source clock
- rst  in  1  synchronous active-high reset
- req_i  in  N_CH  per-channel clock request, level
- ack_o  out  N_CH  per-channel clock-valid acknowledge, registered
- en_o  out  N_CH  gate enables to tech_cg.en, registered, glitch-free
- force_en_i  in  1  test/scan override: all en_o forced high
- idle_i  in  N_CH  per-channel idle indication, sampled only with CG_CTRL_AUTO_IDLE_EN
- busy_o  out  N_CH  channel in WAKE or DRAIN

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst).
- On reset, all channels go to OFF. All outputs are 0: ack_o, en_o, busy_o.
- Channels are independent; each has its own FSM and one shared-width counter (width $clog2(max param + 1)).
- OFF: en=0, ack=0. req_i=1 -> WAKE; counter loads SETTLE_CYCLES-1; en=1 from the next cycle.
- WAKE: en=1, ack=0, busy=1. Counter decrements.
  - Counter==0 and req_i=1 -> ON.
  - req_i=0 at any point -> DRAIN (counter loads DRAIN_CYCLES-1).
- ON: en=1, ack=1. req_i=0 -> DRAIN; ack drops the next cycle.
- DRAIN: en=1, ack=0, busy=1. Counter decrements.
  - Counter==0 -> OFF; en drops the next cycle.
  - req_i=1 during DRAIN -> ON directly; ack=1 the next cycle, no settle, because the clock never stopped.
- Latency:
  - req_i rise in OFF -> en_o rise: 1 cycle.
  - en_o rise -> ack_o rise: SETTLE_CYCLES cycles.
  - req_i fall in ON -> ack_o fall: 1 cycle.
  - ack_o fall -> en_o fall: DRAIN_CYCLES cycles.
- Every en_o 1->0 transition is preceded by ack_o=0 for at least DRAIN_CYCLES cycles.
- force_en_i:
  - en_o = FSM en | force_en_i, applied combinationally after the register. This is the only non-registered path, and the OR gate sits on a quasi-static test signal.
  - Does not alter FSM state or ack_o.
- rst asserted mid-WAKE/DRAIN: channel returns to OFF and en_o=0 the next cycle. Software must not reset while a domain is active.
- Counter never wraps: it loads on entry, decrements, and holds at 0.

Optional Feature:
- Macro: CG_CTRL_AUTO_IDLE_EN.
- Defined:
  - Adds a SLEEP state and a per-channel idle counter.
  - In ON, count consecutive cycles with idle_i=1; reset the count on idle_i=0. Count reaching IDLE_CYCLES -> SLEEP.
  - SLEEP: en=0, ack=1 (grant retained).
    - idle_i=0 -> WAKE with settle; ack stays 1 throughout this re-wake.
    - req_i=0 -> OFF directly.
  - idle_i must originate from the ungated side.
- Undefined: SLEEP and the idle counter are absent, idle_i is unused, and behaviour is exactly as above.

Decomposition:
- Package cg_ctrl_pkg:
  - cg_state_t enum: OFF, WAKE, ON, DRAIN, SLEEP (SLEEP encoded always, reachable only with the macro).
  - Counter width function.
- Sub-module cg_ctrl_ch: single-channel FSM plus counters.
- cg_ctrl: generate loop over N_CH plus the force_en_i OR stage.

Test Plan:
- Wake: reset, then req_i[0]=1 at cycle 10 -> en_o[0]=1 at cycle 11, ack_o[0]=1 at cycle 15 (SETTLE=4); other channels stay 0.
- Release: req_i[0] 1->0 at cycle 30 with ack=1 -> ack_o[0]=0 at 31, busy_o[0]=1, en_o[0]=0 at 39 (DRAIN=8).
- Re-request in DRAIN: req_i[1] drops at cycle 50, rises at 53 -> ack_o[1]=1 at 54, en_o[1] never drops.
- Abort in WAKE: req_i[2] pulses for 2 cycles -> ack_o[2] never asserts; en_o[2] high for 2 + DRAIN cycles, then 0.
- force_en_i=1 with all req_i=0 -> en_o=4'hF the same cycle, ack_o=0. Deassert -> en_o=0 the same cycle.
- With CG_CTRL_AUTO_IDLE_EN, channel 3 in ON, idle_i[3]=1 for 16 cycles -> en_o[3]=0, ack_o[3]=1. Then idle_i[3]=0 -> en_o[3]=1 next cycle, ack_o[3] stays 1.
